// File: rtl/atan_lut_server.sv
// atan_lut_server
//   Registered arctangent lookup server for the CORDIC datapath. Holds
//   atan(2^-i) in degrees (6 int + 10 frac bits) and in radians (2 int +
//   14 frac bits). It serves NCH requesters through a round-robin arbiter
//   and a single synchronous ROM read port. Each channel has at most one
//   request outstanding.
//
//   Handshake: a request is accepted on a rising edge where
//   req_valid[c] & req_ready[c]. A response is consumed on a rising edge
//   where rsp_valid[c] & rsp_ready[c]. Once the server raises rsp_valid[c],
//   it holds rsp_valid[c], rsp_data and rsp_oor stable until the response
//   is consumed.
//
// Ports
//   clock, reset      single rising-edge clock, synchronous active-high reset
//   unit_sel          0 = degrees table, 1 = radians table (sampled at accept)
//   req_valid/ready   per-channel request handshake
//   req_addr          channel c index at [c*AWIDTH +: AWIDTH]
//   rsp_valid/ready   per-channel response handshake
//   rsp_data          channel c result at [c*DWIDTH +: DWIDTH]
//   rsp_oor           index >= DEPTH; rsp_data is then 0
//   dbg_state         channel c FSM state at [2*c +: 2] (0 idle, 1 busy, 2 hold)
module atan_lut_server #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 16,
  parameter int NCH    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     unit_sel,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH*AWIDTH-1:0]    req_addr,
  output logic [NCH-1:0]           req_ready,
  output logic [NCH-1:0]           rsp_valid,
  output logic [NCH*DWIDTH-1:0]    rsp_data,
  output logic [NCH-1:0]           rsp_oor,
  input  logic [NCH-1:0]           rsp_ready,
  output logic [2*NCH-1:0]         dbg_state
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

  // atan(2^-i) * 1024, rounded to nearest
  function automatic logic [15:0] deg_entry(input logic [AWIDTH-1:0] a);
    case (int'(a))
      0:  return 16'hB400;  1:  return 16'h6A43;  2:  return 16'h3825;
      3:  return 16'h1C80;  4:  return 16'h0E4E;  5:  return 16'h0729;
      6:  return 16'h0395;  7:  return 16'h01CA;  8:  return 16'h00E5;
      9:  return 16'h0073;  10: return 16'h0039;  11: return 16'h001D;
      12: return 16'h000E;  13: return 16'h0007;  14: return 16'h0004;
      15: return 16'h0002;
      default: return 16'h0000;
    endcase
  endfunction

  // atan(2^-i) * 16384, rounded to nearest
  function automatic logic [15:0] rad_entry(input logic [AWIDTH-1:0] a);
    case (int'(a))
      0:  return 16'h3244;  1:  return 16'h1DAC;  2:  return 16'h0FAE;
      3:  return 16'h07F5;  4:  return 16'h03FF;  5:  return 16'h0200;
      6:  return 16'h0100;  7:  return 16'h0080;  8:  return 16'h0040;
      9:  return 16'h0020;  10: return 16'h0010;  11: return 16'h0008;
      12: return 16'h0004;  13: return 16'h0002;  14: return 16'h0001;
      15: return 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  logic [1:0]        state [NCH];
  logic [PW-1:0]     ptr;
  logic [NCH-1:0]    eligible;
  logic [NCH-1:0]    grant;
  logic [PW-1:0]     gnt_idx;
  logic              accept;
  logic [AWIDTH-1:0] acc_addr;

  logic              s1_valid;
  logic [PW-1:0]     s1_ch;
  logic [AWIDTH-1:0] s1_addr;
  logic              s1_unit;
  logic              s1_oor;

  logic              s2_valid;
  logic [PW-1:0]     s2_ch;
  logic              s2_oor;
  logic [DWIDTH-1:0] rom_q;

  // A holding channel whose response drains this edge may take a new
  // request on the same edge; this is what gives one result per 3 cycles.
  always_comb begin
    eligible = '0;
    for (int c = 0; c < NCH; c++) begin
      eligible[c] = ~reset & req_valid[c] &
                    ((state[c] == ST_IDLE) | ((state[c] == ST_HOLD) & rsp_ready[c]));
    end
  end

  // Pick the eligible channel with the smallest cyclic distance from ptr.
  always_comb begin : arb
    int d;
    int best_d;
    d       = 0;
    best_d  = NCH;
    gnt_idx = '0;
    for (int c = 0; c < NCH; c++) begin
      d = (c + NCH - int'(ptr)) % NCH;
      if (eligible[c] && (d < best_d)) begin
        best_d  = d;
        gnt_idx = PW'(c);
      end
    end
    accept = (best_d < NCH);
    grant  = '0;
    if (accept) grant[gnt_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign acc_addr  = req_addr[gnt_idx*AWIDTH +: AWIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_addr  <= '0;
      s1_unit  <= 1'b0;
      s1_oor   <= 1'b0;
      s2_valid <= 1'b0;
      s2_ch    <= '0;
      s2_oor   <= 1'b0;
      rom_q    <= '0;
    end else begin
      if (accept) begin
        ptr     <= (gnt_idx == PW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
        s1_ch   <= gnt_idx;
        s1_addr <= acc_addr;
        s1_unit <= unit_sel;
        s1_oor  <= ({1'b0, acc_addr} >= DEPTH_W);
      end
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ch  <= s1_ch;
        s2_oor <= s1_oor;
        rom_q  <= s1_oor ? '0 :
                  (s1_unit ? DWIDTH'(rad_entry(s1_addr)) : DWIDTH'(deg_entry(s1_addr)));
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        state[c]                   <= ST_IDLE;
        rsp_data[c*DWIDTH +: DWIDTH] <= '0;
        rsp_oor[c]                 <= 1'b0;
      end else begin
        // Only a busy channel can have a result in S2, so the write never
        // overwrites a held response.
        if (s2_valid && (s2_ch == PW'(c))) begin
          rsp_data[c*DWIDTH +: DWIDTH] <= rom_q;
          rsp_oor[c]                 <= s2_oor;
        end
        case (state[c])
          ST_IDLE: if (grant[c]) state[c] <= ST_BUSY;
          ST_BUSY: if (s2_valid && (s2_ch == PW'(c))) state[c] <= ST_HOLD;
          ST_HOLD: if (rsp_ready[c]) state[c] <= grant[c] ? ST_BUSY : ST_IDLE;
          default: state[c] <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    dbg_state = '0;
    for (int c = 0; c < NCH; c++) begin
      rsp_valid[c]       = (state[c] == ST_HOLD);
      dbg_state[2*c +: 2] = state[c];
    end
  end

endmodule

// File: tb/tb_atan_lut_server.sv
module tb_atan_lut_server;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int NCH = 2;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              unit_sel;
  logic [NCH-1:0]    req_valid;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    rsp_valid;
  logic [NCH*DW-1:0] rsp_data;
  logic [NCH-1:0]    rsp_oor;
  logic [NCH-1:0]    rsp_ready;
  logic [2*NCH-1:0]  dbg_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  atan_lut_server #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(16), .NCH(NCH)) dut (
    .clock(clock), .reset(reset), .unit_sel(unit_sel),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_oor(rsp_oor),
    .rsp_ready(rsp_ready), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [DW:0] exp_q0[$];
  logic [DW:0] exp_q1[$];
  int grant_q[$];
  int acc0_q[$];
  int acc1_q[$];
  bit log_en = 1'b0;
  int model_ptr = 0;
  int last_acc[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand-computed table entries, {oor, data}
  function automatic logic [DW:0] model(input logic [AW-1:0] a, input logic u);
    if (a >= 5'd16) return {1'b1, 16'h0000};
    if (u) begin
      case (a)
        5'd0:    return {1'b0, 16'h3244};
        5'd1:    return {1'b0, 16'h1DAC};
        default: return {1'b1, 16'hFFFF};
      endcase
    end
    case (a)
      5'd0:    return {1'b0, 16'hB400};
      5'd1:    return {1'b0, 16'h6A43};
      5'd2:    return {1'b0, 16'h3825};
      5'd3:    return {1'b0, 16'h1C80};
      5'd4:    return {1'b0, 16'h0E4E};
      5'd5:    return {1'b0, 16'h0729};
      5'd15:   return {1'b0, 16'h0002};
      default: return {1'b1, 16'hFFFF};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int ch, input logic [AW-1:0] a, input logic u);
    bit done;
    done = 1'b0;
    unit_sel = u;
    req_valid[ch] = 1'b1;
    req_addr[ch*AW +: AW] = a;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clock);
      if (req_ready[ch]) begin
        done = 1'b1;
        if (ch == 0) exp_q0.push_back(model(a, u));
        else         exp_q1.push_back(model(a, u));
        last_acc[ch] = cyc + 1;
        if (log_en) begin
          grant_q.push_back(ch);
          if (ch == 0) acc0_q.push_back(cyc + 1);
          else         acc1_q.push_back(cyc + 1);
        end
        model_ptr = (ch + 1) % NCH;
      end
    end
    check("accept", 32'(done), 32'd1);
    @(posedge clock);
    #1;
    req_valid[ch] = 1'b0;
  endtask

  // Waits for rsp_valid and checks it appeared two edges after the accept.
  task automatic wait_rsp(input int ch, input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clock);
      if (rsp_valid[ch]) seen = 1'b1;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) check({name, "_latency"}, 32'(cyc - last_acc[ch]), 32'd2);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 60) begin
      @(negedge clock);
      t++;
    end
    check("drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic [DW:0] mon_got;
  logic [DW:0] mon_exp;
  bit          mon_have;

  always @(negedge clock) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        if (rsp_valid[c] && rsp_ready[c]) begin
          mon_got  = {rsp_oor[c], rsp_data[c*DW +: DW]};
          mon_have = 1'b0;
          mon_exp  = '0;
          if (c == 0 && exp_q0.size() > 0) begin
            mon_exp = exp_q0.pop_front(); mon_have = 1'b1;
          end else if (c == 1 && exp_q1.size() > 0) begin
            mon_exp = exp_q1.pop_front(); mon_have = 1'b1;
          end
          if (mon_have) check((c == 0) ? "rsp_ch0" : "rsp_ch1", 32'(mon_got), 32'(mon_exp));
          else begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp ch%0d: got %0h, expected no response", c, mon_got);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int first_exp;
    unit_sel  = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = '1;

    // Reset state, with requests pending to show req_ready stays low
    req_valid = '1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data",  32'(rsp_data),  32'd0);
    check("reset_rsp_oor",   32'(rsp_oor),   32'd0);
    check("reset_state",     32'(dbg_state), 32'd0);
    req_valid = '0;
    @(posedge clock);
    #1 reset = 1'b0;
    model_ptr = 0;

    // 1: degrees on ch0
    send(0, 5'd0, 1'b0);
    wait_rsp(0, "t1_a");
    @(posedge clock); #1;
    send(0, 5'd1, 1'b0);
    wait_rsp(0, "t1_b");
    drain();

    // 2: radians on ch1, unit_sel changes after accept
    send(1, 5'd0, 1'b1);
    unit_sel = 1'b0;
    wait_rsp(1, "t2");
    drain();
    send(1, 5'd1, 1'b1);
    drain();

    // 3: contention, both channels valid throughout
    first_exp = model_ptr;
    grant_q.delete(); acc0_q.delete(); acc1_q.delete();
    log_en = 1'b1;
    fork
      begin
        send(0, 5'd0, 1'b0); send(0, 5'd1, 1'b0); send(0, 5'd2, 1'b0); send(0, 5'd3, 1'b0);
      end
      begin
        send(1, 5'd4, 1'b0); send(1, 5'd5, 1'b0); send(1, 5'd15, 1'b0); send(1, 5'd16, 1'b0);
      end
    join
    log_en = 1'b0;
    check("t3_grant_count", 32'(grant_q.size()), 32'd8);
    if (grant_q.size() > 0) check("t3_first_grant", 32'(grant_q[0]), 32'(first_exp));
    for (int i = 1; i < grant_q.size(); i++)
      check("t3_alternate", 32'(grant_q[i] != grant_q[i-1]), 32'd1);
    for (int i = 1; i < acc0_q.size(); i++)
      check("t3_ch0_period", 32'(acc0_q[i] - acc0_q[i-1]), 32'd3);
    for (int i = 1; i < acc1_q.size(); i++)
      check("t3_ch1_period", 32'(acc1_q[i] - acc1_q[i-1]), 32'd3);
    drain();

    // 4: backpressure on ch0 while ch1 keeps completing
    rsp_ready = 2'b10;
    send(0, 5'd2, 1'b0);
    wait_rsp(0, "t4");
    req_valid[0] = 1'b1;
    @(posedge clock); #1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          req_addr[0 +: AW] = AW'($urandom_range(0, 31));
          @(negedge clock);
          check("t4_hold_valid", 32'(rsp_valid[0]),   32'd1);
          check("t4_hold_data",  32'(rsp_data[0 +: DW]), 32'h3825);
          check("t4_hold_oor",   32'(rsp_oor[0]),     32'd0);
          check("t4_no_ready",   32'(req_ready[0]),   32'd0);
        end
      end
      begin
        send(1, 5'd4, 1'b0);
        send(1, 5'd5, 1'b0);
      end
    join
    check("t4_ch1_progress", 32'(exp_q1.size()), 32'd0);
    @(posedge clock); #1;
    rsp_ready = 2'b11;
    send(0, 5'd3, 1'b0);
    wait_rsp(0, "t4_after");
    drain();

    // 5: out-of-range indices, then the last valid index
    send(0, 5'd16, 1'b0);
    send(0, 5'd31, 1'b0);
    send(0, 5'd15, 1'b0);
    drain();

    // 6: reset one cycle after an accept
    send(0, 5'd1, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    exp_q0.delete();
    reset = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t6_no_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clock); #1;
    grant_q.delete();
    log_en = 1'b1;
    fork
      send(0, 5'd4, 1'b0);
      send(1, 5'd5, 1'b0);
    join
    log_en = 1'b0;
    check("t6_grant_count", 32'(grant_q.size()), 32'd2);
    if (grant_q.size() > 0) check("t6_ptr_reset", 32'(grant_q[0]), 32'd0);
    wait_rsp(0, "t6_first");
    drain();

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
